// File: rtl/testbasic23_sink_pkg.sv
// Shared types, constants and the sum/saturate helper for the TestBasic23 sink.
package testbasic23_sink_types;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SUM_W  = 34;

  localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    SEC_RD_U,
    SEC_RD_S,
    SEC_WR
  } Sections_sink;

  // Unsigned + signed in 34 bits; the top three bits agree exactly when the result fits an int32.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] val_unsigned,
                                                 input logic [DATA_W-1:0] val_signed,
                                                 input logic              saturate);
    logic signed [SUM_W-1:0] s;
    s = $signed({2'b00, val_unsigned}) + $signed({{2{val_signed[DATA_W-1]}}, val_signed});
    sat_add = s[DATA_W-1:0];
    if (saturate) begin
      if (!s[SUM_W-1] && (s[SUM_W-2:DATA_W-1] != 2'b00)) begin
        sat_add = INT_MAX;
      end else if (s[SUM_W-1] && (s[SUM_W-2:DATA_W-1] != 2'b11)) begin
        sat_add = INT_MIN;
      end
    end
  endfunction

endpackage

// File: rtl/testbasic23_sink_if.sv
// Sync/notify handshake bundle between the TestBasic23 producer, sink and downstream consumer.
interface testbasic23_sink_if #(
  parameter int unsigned COUNT_W = 8
);
  import testbasic23_sink_types::*;

  logic [DATA_W-1:0]  b_in;
  logic               b_in_sync;
  logic               b_in_notify;
  logic [DATA_W-1:0]  b_in2;
  logic               b_in2_sync;
  logic               b_in2_notify;
  logic [DATA_W-1:0]  sum_out;
  logic               sum_out_sync;
  logic               sum_out_notify;
  logic [COUNT_W-1:0] count_out;

  modport master (
    output b_in, b_in_sync, b_in2, b_in2_sync, sum_out_sync,
    input  b_in_notify, b_in2_notify, sum_out, sum_out_notify, count_out
  );

  modport slave (
    input  b_in, b_in_sync, b_in2, b_in2_sync, sum_out_sync,
    output b_in_notify, b_in2_notify, sum_out, sum_out_notify, count_out
  );
endinterface

// File: rtl/testbasic23_sink.sv
// TestBasic23 sink: reads an unsigned then a signed word, emits their (optionally
// saturated) sum and counts completed result transfers.
module testbasic23_sink
  import testbasic23_sink_types::*;
#(
  parameter int unsigned COUNT_W  = 8,
  parameter bit          SATURATE = 1'b0
) (
  input logic               clk,
  input logic               rst,
  testbasic23_sink_if.slave bus
);

  Sections_sink       state_q, state_d;
  logic [DATA_W-1:0]  val_unsigned_q, val_unsigned_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               b_in_notify_q, b_in_notify_d;
  logic               b_in2_notify_q, b_in2_notify_d;
  logic               sum_notify_q, sum_notify_d;

  // Next-state: a port transfers only when its own notify is high, so stray syncs fall through.
  always_comb begin
    state_d        = state_q;
    val_unsigned_d = val_unsigned_q;
    sum_d          = sum_q;
    count_d        = count_q;
    b_in_notify_d  = b_in_notify_q;
    b_in2_notify_d = b_in2_notify_q;
    sum_notify_d   = sum_notify_q;

    unique case (state_q)
      SEC_RD_U: begin
        if (b_in_notify_q && bus.b_in_sync) begin
          val_unsigned_d = bus.b_in;
          b_in_notify_d  = 1'b0;
          b_in2_notify_d = 1'b1;
          state_d        = SEC_RD_S;
        end
      end
      SEC_RD_S: begin
        if (b_in2_notify_q && bus.b_in2_sync) begin
          sum_d          = sat_add(val_unsigned_q, bus.b_in2, SATURATE);
          b_in2_notify_d = 1'b0;
          sum_notify_d   = 1'b1;
          state_d        = SEC_WR;
        end
      end
      SEC_WR: begin
        if (sum_notify_q && bus.sum_out_sync) begin
          sum_notify_d  = 1'b0;
          count_d       = count_q + COUNT_W'(1);
          b_in_notify_d = 1'b1;
          state_d       = SEC_RD_U;
        end
      end
      default: begin
        state_d        = SEC_RD_U;
        b_in_notify_d  = 1'b1;
        b_in2_notify_d = 1'b0;
        sum_notify_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= SEC_RD_U;
      val_unsigned_q <= '0;
      sum_q          <= '0;
      count_q        <= '0;
      b_in_notify_q  <= 1'b1;
      b_in2_notify_q <= 1'b0;
      sum_notify_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      val_unsigned_q <= val_unsigned_d;
      sum_q          <= sum_d;
      count_q        <= count_d;
      b_in_notify_q  <= b_in_notify_d;
      b_in2_notify_q <= b_in2_notify_d;
      sum_notify_q   <= sum_notify_d;
    end
  end

  assign bus.b_in_notify    = b_in_notify_q;
  assign bus.b_in2_notify   = b_in2_notify_q;
  assign bus.sum_out        = sum_q;
  assign bus.sum_out_notify = sum_notify_q;
  assign bus.count_out      = count_q;

endmodule

// File: tb/tb_testbasic23_sink.sv
// Bench for testbasic23_sink: wrapping and saturating instances driven in lockstep
// and compared against an arithmetic reference model.
module tb_testbasic23_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] b_in, b_in2;
  logic        b_in_sync, b_in2_sync, sum_out_sync;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  cnt_model;

  testbasic23_sink_if #(.COUNT_W(8)) if_w ();
  testbasic23_sink_if #(.COUNT_W(8)) if_s ();

  assign if_w.b_in = b_in;          assign if_s.b_in = b_in;
  assign if_w.b_in_sync = b_in_sync; assign if_s.b_in_sync = b_in_sync;
  assign if_w.b_in2 = b_in2;        assign if_s.b_in2 = b_in2;
  assign if_w.b_in2_sync = b_in2_sync; assign if_s.b_in2_sync = b_in2_sync;
  assign if_w.sum_out_sync = sum_out_sync; assign if_s.sum_out_sync = sum_out_sync;

  testbasic23_sink #(.COUNT_W(8), .SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(if_w.slave));
  testbasic23_sink #(.COUNT_W(8), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, then either truncate to 32 bits or clamp to int32.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input bit sat);
    longint s;
    s = longint'(a) + longint'($signed(b));
    if (sat && s > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (sat && s < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // Protocol invariant: never more than one notify high per instance.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("onehot_w", 64'($countones({if_w.b_in_notify, if_w.b_in2_notify, if_w.sum_out_notify}) <= 1), 64'd1);
      check("onehot_s", 64'($countones({if_s.b_in_notify, if_s.b_in2_notify, if_s.sum_out_notify}) <= 1), 64'd1);
    end
  end

  task automatic check_notify(input string tag, input logic [2:0] exp);
    check({tag, "_notify_w"}, 64'({if_w.b_in_notify, if_w.b_in2_notify, if_w.sum_out_notify}), 64'(exp));
    check({tag, "_notify_s"}, 64'({if_s.b_in_notify, if_s.b_in2_notify, if_s.sum_out_notify}), 64'(exp));
  endtask

  task automatic check_count(input string tag);
    check({tag, "_count_w"}, 64'(if_w.count_out), 64'(cnt_model));
    check({tag, "_count_s"}, 64'(if_s.count_out), 64'(cnt_model));
  endtask

  // One transaction entered at a negedge in SEC_RD_U with every sync raised; hold = cycles of sum_out_sync low.
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_w,
                     input logic [31:0] exp_s, input int hold, input bit early);
    if (early) begin
      b_in_sync = 1'b0; b_in2 = b; b_in2_sync = 1'b1; sum_out_sync = 1'b1;
      @(posedge clk); @(negedge clk);
      check_notify("early_pulse", 3'b100);
    end
    b_in = a; b_in_sync = 1'b1; b_in2 = b; b_in2_sync = 1'b1; sum_out_sync = (hold == 0);
    @(posedge clk); @(negedge clk);
    check_notify("rd_s", 3'b010);
    b_in = $urandom();
    @(posedge clk); @(negedge clk);
    check_notify("wr", 3'b001);
    check("sum_wrap", 64'(if_w.sum_out), 64'(exp_w));
    check("sum_sat", 64'(if_s.sum_out), 64'(exp_s));
    b_in2 = $urandom();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check_notify("hold", 3'b001);
      check("hold_sum_w", 64'(if_w.sum_out), 64'(exp_w));
      check("hold_sum_s", 64'(if_s.sum_out), 64'(exp_s));
      check_count("hold");
      if (i == hold - 1) sum_out_sync = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    cnt_model = cnt_model + 8'd1;
    check_notify("done", 3'b100);
    check_count("done");
  endtask

  task automatic rand_txn(input bit early);
    logic [31:0] a, b;
    a = $urandom();
    b = $urandom();
    if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFF;
    if ($urandom_range(0, 5) == 0) b = 32'h8000_0000;
    txn(a, b, ref_sum(a, b, 1'b0), ref_sum(a, b, 1'b1), 0, early);
  endtask

  initial begin
    rst = 1'b1; b_in = '0; b_in2 = '0; b_in_sync = 1'b0; b_in2_sync = 1'b0; sum_out_sync = 1'b0;
    cnt_model = 8'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing moves while all syncs are low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_notify("idle", 3'b100);
      check("idle_sum_w", 64'(if_w.sum_out), 64'd0);
      check("idle_sum_s", 64'(if_s.sum_out), 64'd0);
      check_count("idle");
    end

    txn(32'd13, 32'hFFFF_FFF9, 32'd6, 32'd6, 0, 1'b0);
    check("first_count", 64'(if_w.count_out), 64'd1);
    txn(32'd100, 32'hFFFF_FF9C, 32'd0, 32'd0, 0, 1'b0);
    txn(32'd7, 32'd8, 32'd15, 32'd15, 10, 1'b0);
    txn(32'hFFFF_FFFF, 32'd5, 32'd4, 32'h7FFF_FFFF, 0, 1'b0);
    txn(32'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
    txn(32'h8000_0000, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 3, 1'b0);

    // Asynchronous reset while a result is waiting downstream.
    b_in = 32'd50; b_in_sync = 1'b1; b_in2 = 32'd60; b_in2_sync = 1'b1; sum_out_sync = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_notify("pre_rst", 3'b001);
    #2 rst = 1'b1;
    #1;
    check_notify("async_rst", 3'b100);
    check("async_rst_sum_w", 64'(if_w.sum_out), 64'd0);
    check("async_rst_sum_s", 64'(if_s.sum_out), 64'd0);
    check("async_rst_count", 64'(if_w.count_out), 64'd0);
    b_in_sync = 1'b0; b_in2_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt_model = 8'd0;
    @(negedge clk);
    check_notify("post_rst", 3'b100);

    txn(32'd20, 32'hFFFF_FFFB, 32'd15, 32'd15, 0, 1'b0);
    check("post_rst_count", 64'(if_s.count_out), 64'd1);

    // Remaining 255 of a 256-transaction back-to-back run; count wraps to zero.
    for (int i = 0; i < 255; i++) rand_txn(i % 37 == 5);
    check("wrap_count_w", 64'(if_w.count_out), 64'd0);
    check("wrap_count_s", 64'(if_s.count_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
